// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: debounced start/stop and lap/clear keys, run/lap/pause FSM,
// BCD min:s:cs counter and registered seven-segment outputs.
module stopwatch_ctrl #(
    parameter int unsigned CLK_HZ          = 50_000_000,
    parameter int unsigned TICK_HZ         = 100,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        button_0,
    input  logic        button_1,
    input  logic [1:0]  switches,
    output logic [13:0] segm_min,
    output logic [13:0] segm_s,
    output logic [13:0] segm_ms,
    output logic        running
);

    localparam int unsigned DivCycles = CLK_HZ / TICK_HZ;
    localparam int unsigned PreWidth  = (DivCycles > 1) ? $clog2(DivCycles) : 1;
    localparam int unsigned DbWidth   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [PreWidth-1:0] PreMax = PreWidth'(DivCycles - 1);
    localparam logic [DbWidth-1:0]  DbMax  = DbWidth'(DEBOUNCE_CYCLES - 1);
    localparam logic [23:0] TimeMax = 24'h995999;
    localparam logic [13:0] SegZero = 14'h2040;

    typedef enum logic [1:0] {StIdle, StRun, StLap, StPause} state_e;

    state_e                      state_q, state_d;
    logic [1:0]                  sync1_q, sync2_q;
    logic [1:0]                  db_q, db_d;
    logic [1:0][DbWidth-1:0]     db_cnt_q, db_cnt_d;
    logic [1:0]                  press_q, press_d;
    logic [PreWidth-1:0]         pre_q, pre_d;
    logic [23:0]                 time_q, time_d;
    logic [23:0]                 lap_q, lap_d;
    logic [23:0]                 disp_time;
    logic [13:0]                 segm_min_q, segm_min_d;
    logic [13:0]                 segm_s_q, segm_s_d;
    logic [13:0]                 segm_ms_q, segm_ms_d;
    logic                        running_q, running_d;
    logic                        advancing, tick, sat_stop;

    // Digit layout {min_t, min_u, s_t, s_u, cs_t, cs_u}; seconds tens wraps at 5.
    function automatic logic [23:0] bcd_inc(input logic [23:0] t);
        logic [23:0] r;
        logic        carry;
        r     = t;
        carry = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (carry) begin
                if (t[i*4 +: 4] == ((i == 3) ? 4'd5 : 4'd9)) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = t[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Debounce: accept the synchronized level once it has disagreed for DEBOUNCE_CYCLES samples.
    always_comb begin
        db_d     = db_q;
        db_cnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DbMax) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
        press_d = db_q & ~db_d;
    end

    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q;
        time_d    = time_q;
        lap_d     = lap_q;
        tick      = 1'b0;
        sat_stop  = 1'b0;
        advancing = (state_q == StRun) || (state_q == StLap);

        if (advancing) begin
            if (pre_q == PreMax) begin
                tick  = 1'b1;
                pre_d = '0;
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end

        if (tick) begin
            if ((time_q == TimeMax) && switches[0]) begin
                sat_stop = 1'b1;
            end else begin
                time_d = bcd_inc(time_q);
            end
        end

        // press_q[0] is checked first everywhere so a coincident b1 event is dropped.
        unique case (state_q)
            StIdle: begin
                if (press_q[0]) begin
                    state_d = StRun;
                    pre_d   = '0;
                end
            end
            StRun: begin
                if (press_q[0]) begin
                    state_d = StPause;
                end else if (press_q[1]) begin
                    state_d = StLap;
                    lap_d   = time_q;
                end
            end
            StLap: begin
                if (press_q[0]) begin
                    state_d = StPause;
                end else if (press_q[1]) begin
                    state_d = StRun;
                end
            end
            StPause: begin
                if (press_q[0]) begin
                    state_d = StRun;
                end else if (press_q[1]) begin
                    state_d = StIdle;
                    time_d  = '0;
                    lap_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (sat_stop) begin
            state_d = StPause;
            lap_d   = lap_q;
        end

        running_d = (state_d == StRun) || (state_d == StLap);
    end

    always_comb begin
        disp_time = (state_q == StLap) ? lap_q : time_q;
        if (switches[1]) begin
            segm_min_d = {seg7(disp_time[23:20]), seg7(disp_time[19:16])};
            segm_s_d   = {seg7(disp_time[15:12]), seg7(disp_time[11:8])};
            segm_ms_d  = {seg7(disp_time[7:4]), seg7(disp_time[3:0])};
        end else begin
            segm_min_d = 14'h3FFF;
            segm_s_d   = 14'h3FFF;
            segm_ms_d  = 14'h3FFF;
        end
    end

    // Button paths reset to the released (high) level so reset release creates no event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 2'b11;
            sync2_q    <= 2'b11;
            db_q       <= 2'b11;
            db_cnt_q   <= '0;
            press_q    <= 2'b00;
            state_q    <= StIdle;
            pre_q      <= '0;
            time_q     <= '0;
            lap_q      <= '0;
            segm_min_q <= SegZero;
            segm_s_q   <= SegZero;
            segm_ms_q  <= SegZero;
            running_q  <= 1'b0;
        end else begin
            sync1_q    <= {button_1, button_0};
            sync2_q    <= sync1_q;
            db_q       <= db_d;
            db_cnt_q   <= db_cnt_d;
            press_q    <= press_d;
            state_q    <= state_d;
            pre_q      <= pre_d;
            time_q     <= time_d;
            lap_q      <= lap_d;
            segm_min_q <= segm_min_d;
            segm_s_q   <= segm_s_d;
            segm_ms_q  <= segm_ms_d;
            running_q  <= running_d;
        end
    end

    assign segm_min = segm_min_q;
    assign segm_s   = segm_s_q;
    assign segm_ms  = segm_ms_q;
    assign running  = running_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: cycle model on integer centiseconds plus directed literal checks.
module tb_stopwatch_ctrl;

    localparam int DIV  = 10;
    localparam int DEB  = 4;
    localparam int MAXT = 599999;
    localparam int ST_IDLE  = 0;
    localparam int ST_RUN   = 1;
    localparam int ST_LAP   = 2;
    localparam int ST_PAUSE = 3;
    localparam logic [6:0] SEG_TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    logic        clk;
    logic        rst_n;
    logic        button_0;
    logic        button_1;
    logic [1:0]  switches;
    logic [13:0] segm_min;
    logic [13:0] segm_s;
    logic [13:0] segm_ms;
    logic        running;

    int total;
    int bad;
    bit pl_req;
    int pl_val;

    stopwatch_ctrl #(
        .CLK_HZ         (1000),
        .TICK_HZ        (100),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .button_0(button_0),
        .button_1(button_1),
        .switches(switches),
        .segm_min(segm_min),
        .segm_s  (segm_s),
        .segm_ms (segm_ms),
        .running (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        int          t;
        int          lap;
        int          pre;
        int          st;
        int          cnt0;
        int          cnt1;
        logic [1:0]  s1;
        logic [1:0]  s2;
        logic [1:0]  db;
        logic [1:0]  press;
        logic [13:0] min;
        logic [13:0] sec;
        logic [13:0] cs;
        logic        run;
    } model_t;

    model_t m;

    function automatic logic [13:0] enc2(input int v);
        return {SEG_TAB[v / 10], SEG_TAB[v % 10]};
    endfunction

    function automatic model_t model_reset();
        model_t r;
        r       = '0;
        r.s1    = 2'b11;
        r.s2    = 2'b11;
        r.db    = 2'b11;
        r.min   = 14'h2040;
        r.sec   = 14'h2040;
        r.cs    = 14'h2040;
        return r;
    endfunction

    // Time is held as total centiseconds; digits come from division.
    function automatic model_t step(input model_t c, input logic [1:0] btn,
                                    input logic [1:0] swv, input bit pl, input int plv);
        model_t     r;
        int         cur, src, n0, n1, ns;
        bit         adv, tick, stop;
        logic [1:0] ndb;
        r   = c;
        cur = pl ? plv : c.t;
        src = (c.st == ST_LAP) ? c.lap : cur;
        if (swv[1]) begin
            r.min = enc2(src / 6000);
            r.sec = enc2((src / 100) % 60);
            r.cs  = enc2(src % 100);
        end else begin
            r.min = 14'h3FFF;
            r.sec = 14'h3FFF;
            r.cs  = 14'h3FFF;
        end
        ndb = c.db;
        n0  = (c.s2[0] != c.db[0]) ? c.cnt0 + 1 : 0;
        if (n0 == DEB) begin
            ndb[0] = c.s2[0];
            n0     = 0;
        end
        n1  = (c.s2[1] != c.db[1]) ? c.cnt1 + 1 : 0;
        if (n1 == DEB) begin
            ndb[1] = c.s2[1];
            n1     = 0;
        end
        r.cnt0  = n0;
        r.cnt1  = n1;
        r.db    = ndb;
        r.press = c.db & ~ndb;
        r.s2    = c.s1;
        r.s1    = btn;
        adv  = (c.st == ST_RUN) || (c.st == ST_LAP);
        tick = adv && (c.pre == DIV - 1);
        if (adv) r.pre = (c.pre + 1) % DIV;
        r.t  = cur;
        stop = 1'b0;
        if (tick) begin
            if (cur == MAXT && swv[0]) stop = 1'b1;
            else r.t = (cur + 1) % (MAXT + 1);
        end
        ns = c.st;
        case (c.st)
            ST_IDLE: if (c.press[0]) begin ns = ST_RUN; r.pre = 0; end
            ST_RUN: begin
                if (c.press[0]) ns = ST_PAUSE;
                else if (c.press[1]) begin ns = ST_LAP; r.lap = cur; end
            end
            ST_LAP: begin
                if (c.press[0]) ns = ST_PAUSE;
                else if (c.press[1]) ns = ST_RUN;
            end
            ST_PAUSE: begin
                if (c.press[0]) ns = ST_RUN;
                else if (c.press[1]) begin ns = ST_IDLE; r.t = 0; r.lap = 0; end
            end
            default: ns = c.st;
        endcase
        if (stop) begin
            ns    = ST_PAUSE;
            r.lap = c.lap;
        end
        r.st  = ns;
        r.run = (ns == ST_RUN) || (ns == ST_LAP);
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= model_reset();
        else m <= step(m, {button_1, button_0}, switches, pl_req, pl_val);
    end

    task automatic chk(input string name, input logic [13:0] act, input logic [13:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("model_min", segm_min, m.min);
            chk("model_s", segm_s, m.sec);
            chk("model_ms", segm_ms, m.cs);
            chk("model_running", {13'd0, running}, {13'd0, m.run});
        end
    endtask

    task automatic press(input bit p0, input bit p1);
        if (p0) button_0 = 1'b0;
        if (p1) button_1 = 1'b0;
        cycles(20);
        button_0 = 1'b1;
        button_1 = 1'b1;
        cycles(10);
    endtask

    task automatic preload(input int v, input logic [23:0] bcd);
        force dut.time_q = bcd;
        pl_val = v;
        pl_req = 1'b1;
        cycles(1);
        release dut.time_q;
        pl_req = 1'b0;
        cycles(1);
    endtask

    task automatic chk_all(input string name, input logic [13:0] mn, input logic [13:0] s,
                           input logic [13:0] cs, input logic run);
        chk({name, "_min"}, segm_min, mn);
        chk({name, "_s"}, segm_s, s);
        chk({name, "_ms"}, segm_ms, cs);
        chk({name, "_running"}, {13'd0, running}, {13'd0, run});
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        pl_req   = 1'b0;
        pl_val   = 0;
        button_0 = 1'b1;
        button_1 = 1'b1;
        switches = 2'b10;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state, and nothing moves in IDLE.
        chk_all("reset", 14'h2040, 14'h2040, 14'h2040, 1'b0);
        cycles(100);
        chk_all("idle_hold", 14'h2040, 14'h2040, 14'h2040, 1'b0);

        // Start, then 123 ticks -> 00:01.23.
        press(1'b1, 1'b0);
        cycles(1213);
        chk_all("run_123", 14'h2040, 14'h2079, {7'h24, 7'h30}, 1'b1);

        // Short glitch is filtered; lap freezes at 00:01.25; second lap press resumes live.
        button_1 = 1'b0;
        cycles(2);
        button_1 = 1'b1;
        cycles(10);
        chk("glitch_running", {13'd0, running}, 14'd1);
        press(1'b0, 1'b1);
        chk_all("lap", 14'h2040, 14'h2079, {7'h24, 7'h12}, 1'b1);
        cycles(100);
        chk("lap_frozen_ms", segm_ms, {7'h24, 7'h12});
        press(1'b0, 1'b1);
        chk_all("lap_live", 14'h2040, 14'h2079, {7'h19, 7'h40}, 1'b1);

        // Wrap at 99:59.99 with saturation off.
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        preload(599998, 24'h995998);
        switches = 2'b10;
        press(1'b1, 1'b0);
        chk_all("wrap", 14'h2040, 14'h2040, 14'h2040, 1'b1);

        // Saturate at 99:59.99 and drop into PAUSE.
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        preload(599998, 24'h995998);
        switches = 2'b11;
        press(1'b1, 1'b0);
        chk_all("sat", 14'h0810, 14'h0910, 14'h0810, 1'b0);
        cycles(30);
        chk_all("sat_hold", 14'h0810, 14'h0910, 14'h0810, 1'b0);

        // Coincident b0/b1 in RUN -> PAUSE; then b1 clears to IDLE.
        press(1'b0, 1'b1);
        switches = 2'b10;
        press(1'b1, 1'b0);
        cycles(40);
        press(1'b1, 1'b1);
        chk("both_running", {13'd0, running}, 14'd0);
        press(1'b0, 1'b1);
        chk_all("clear", 14'h2040, 14'h2040, 14'h2040, 1'b0);

        // Blanking while running, then asynchronous reset mid-run.
        press(1'b1, 1'b0);
        cycles(30);
        switches = 2'b00;
        cycles(1);
        chk_all("blank", 14'h3FFF, 14'h3FFF, 14'h3FFF, 1'b1);
        cycles(25);
        switches = 2'b10;
        cycles(5);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 14'h2040, 14'h2040, 14'h2040, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cycles(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
